hwag_tooth_sync: RTL and testbench

- Parametrised crank-wheel synchroniser for the HWAG angle generator.
- Measures the tooth-to-tooth period from the filtered VR edge pulse.
- Finds the missing-tooth gap and tracks the tooth index per revolution.
- Flags lost sync, stall and overflow. It sits after the VR capture filter and feeds period and tooth index to the angle generator and to the interrupt flag register.

---
 rtl/hwag_tooth_sync.sv | 203 ++++++++++++++++++++
 tb/tb_hwag_tooth_sync.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwag_tooth_sync.sv
// hwag_tooth_sync: crank-wheel synchroniser for the HWAG angle generator.
// Measures the tooth-to-tooth period from the filtered edge pulse, finds the
// missing-tooth gap and tracks the tooth index within one revolution.
// Optional build macro HWAG_GAP_CONFIRM_EN: during acquisition a gap candidate
// is only accepted once the following tooth is shorter than half the gap.
module hwag_tooth_sync #(
    parameter int CNT_W   = 24,
    parameter int TOOTH_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               edge_in,
    input  logic [TOOTH_W-1:0] teeth_num,
    output logic [CNT_W-1:0]   period_out,
    output logic               period_vld,
    output logic [TOOTH_W-1:0] tooth_idx,
    output logic               synced,
    output logic               gap_det,
    output logic               sync_err,
    output logic               ovf
);

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [TOOTH_W-1:0] TOOTH_ONE = {{(TOOTH_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SEEK_FIRST = 3'd1,
        S_MEASURE    = 3'd2,
        S_SEEK_GAP   = 3'd3,
        S_SYNCED     = 3'd4
`ifdef HWAG_GAP_CONFIRM_EN
        ,
        S_CONFIRM    = 3'd5
`endif
    } state_t;

    // Period of the tooth ending now: one more than the counter, pinned at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + CNT_ONE;
    endfunction

    // Gap when the new period is at least twice the previous one; no history, no gap.
    function automatic logic is_gap(input logic [CNT_W-1:0] p_new,
                                    input logic [CNT_W-1:0] p_old);
        return (p_old != '0) && ({1'b0, p_new} >= {p_old, 1'b0});
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   prev_q, prev_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               period_vld_q, period_vld_d;
    logic [TOOTH_W-1:0] tooth_idx_q, tooth_idx_d;
    logic               gap_det_q, gap_det_d;
    logic               sync_err_q, sync_err_d;
    logic               ovf_q, ovf_d;
`ifdef HWAG_GAP_CONFIRM_EN
    logic [CNT_W-1:0]   gapp_q, gapp_d;
`endif

    logic [CNT_W-1:0]   cur;
    logic               gap;
    logic               last_tooth;

    // Next state, period counter and registered outputs for the coming clock
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prev_d       = prev_q;
        period_d     = period_q;
        tooth_idx_d  = tooth_idx_q;
        period_vld_d = 1'b0;
        gap_det_d    = 1'b0;
        sync_err_d   = 1'b0;
        ovf_d        = 1'b0;
`ifdef HWAG_GAP_CONFIRM_EN
        gapp_d       = gapp_q;
`endif
        cur        = sat_inc(cnt_q);
        gap        = is_gap(cur, prev_q);
        last_tooth = (tooth_idx_q == teeth_num - TOOTH_ONE);

        if (!ena) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            prev_d      = '0;
            period_d    = '0;
            tooth_idx_d = '0;
`ifdef HWAG_GAP_CONFIRM_EN
            gapp_d      = '0;
`endif
        end else if (state_q == S_IDLE) begin
            state_d = S_SEEK_FIRST;
        end else if ((cnt_q == CNT_MAX) && !edge_in) begin
            // Stall: wheel stopped or sensor lost, start acquisition over
            ovf_d       = 1'b1;
            cnt_d       = '0;
            state_d     = S_SEEK_FIRST;
            tooth_idx_d = '0;
        end else if (edge_in) begin
            cnt_d = '0;
            // The very first edge only starts the measurement, it closes no period
            if (state_q != S_SEEK_FIRST) begin
                period_d     = cur;
                prev_d       = cur;
                period_vld_d = 1'b1;
            end
            case (state_q)
                S_SEEK_FIRST: state_d = S_MEASURE;
                S_MEASURE:    state_d = S_SEEK_GAP;
                S_SEEK_GAP: begin
                    if (gap) begin
`ifdef HWAG_GAP_CONFIRM_EN
                        state_d = S_CONFIRM;
                        gapp_d  = cur;
`else
                        state_d     = S_SYNCED;
                        tooth_idx_d = '0;
                        gap_det_d   = 1'b1;
`endif
                    end
                end
`ifdef HWAG_GAP_CONFIRM_EN
                S_CONFIRM: begin
                    if ({cur, 1'b0} < {1'b0, gapp_q}) begin
                        state_d     = S_SYNCED;
                        tooth_idx_d = TOOTH_ONE;
                        gap_det_d   = 1'b1;
                    end else begin
                        state_d = S_SEEK_GAP;
                    end
                end
`endif
                S_SYNCED: begin
                    // A gap must arrive exactly on the last tooth; anything else is lost sync
                    if ((teeth_num == '0) || (gap != last_tooth)) begin
                        sync_err_d  = 1'b1;
                        state_d     = S_SEEK_GAP;
                        tooth_idx_d = '0;
                    end else if (gap) begin
                        gap_det_d   = 1'b1;
                        tooth_idx_d = '0;
                    end else begin
                        tooth_idx_d = tooth_idx_q + TOOTH_ONE;
                    end
                end
                default: ;
            endcase
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, period history and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            prev_q       <= '0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
            tooth_idx_q  <= '0;
            gap_det_q    <= 1'b0;
            sync_err_q   <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef HWAG_GAP_CONFIRM_EN
            gapp_q       <= '0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
            tooth_idx_q  <= tooth_idx_d;
            gap_det_q    <= gap_det_d;
            sync_err_q   <= sync_err_d;
            ovf_q        <= ovf_d;
`ifdef HWAG_GAP_CONFIRM_EN
            gapp_q       <= gapp_d;
`endif
        end
    end

    assign period_out = period_q;
    assign period_vld = period_vld_q;
    assign tooth_idx  = tooth_idx_q;
    assign synced     = (state_q == S_SYNCED);
    assign gap_det    = gap_det_q;
    assign sync_err   = sync_err_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_hwag_tooth_sync.sv
// Bench for hwag_tooth_sync: directed wheel scenarios plus a randomized wheel,
// checked every cycle against a timestamp-based reference model.
module tb_hwag_tooth_sync;

    localparam int CW   = 8;
    localparam int TW   = 8;
    localparam int SAT  = 1 << CW;
    localparam int CMAX = SAT - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          edge_in;
    logic [TW-1:0] teeth_num;
    logic [CW-1:0] period_out;
    logic          period_vld;
    logic [TW-1:0] tooth_idx;
    logic          synced;
    logic          gap_det;
    logic          sync_err;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    hwag_tooth_sync #(.CNT_W(CW), .TOOTH_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .edge_in    (edge_in),
        .teeth_num  (teeth_num),
        .period_out (period_out),
        .period_vld (period_vld),
        .tooth_idx  (tooth_idx),
        .synced     (synced),
        .gap_det    (gap_det),
        .sync_err   (sync_err),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: time since the last reference event instead of a counter
    int m_now = 0;
    int m_ref;
    bit m_active, m_first, m_meas, m_lock, m_pend;
    int m_prev, m_gapp, m_period, m_idx;
    bit e_vld, e_gap, e_err, e_ovf;
    int last_p = 40;

    task automatic model_clear();
        m_active = 0; m_first = 0; m_meas = 0; m_lock = 0; m_pend = 0;
        m_ref = 0; m_prev = 0; m_gapp = 0; m_period = 0; m_idx = 0;
        e_vld = 0; e_gap = 0; e_err = 0; e_ovf = 0;
    endtask

    task automatic model_lose();
        e_err = 1; m_lock = 0; m_idx = 0;
    endtask

    task automatic model_step(input logic e);
        int  elapsed;
        int  cur;
        bit  gap_ok;
        e_vld = 0; e_gap = 0; e_err = 0; e_ovf = 0;
        m_now++;
        if (rst || !ena) begin
            model_clear();
        end else if (!m_active) begin
            m_active = 1;
            m_ref    = m_now;
        end else begin
            elapsed = m_now - m_ref;
            if (!e) begin
                if (elapsed == SAT) begin
                    e_ovf = 1; m_ref = m_now;
                    m_first = 0; m_meas = 0; m_lock = 0; m_pend = 0; m_idx = 0;
                end
            end else begin
                cur   = (elapsed >= SAT) ? CMAX : elapsed;
                m_ref = m_now;
                if (!m_first) begin
                    m_first = 1;
                end else begin
                    e_vld    = 1;
                    m_period = cur;
                    gap_ok   = (m_prev != 0) && (cur >= 2 * m_prev);
                    if (!m_meas) begin
                        m_meas = 1;
                    end else if (m_lock) begin
                        if (teeth_num == 0) model_lose();
                        else if (m_idx == int'(teeth_num) - 1) begin
                            if (gap_ok) begin e_gap = 1; m_idx = 0; end
                            else model_lose();
                        end else if (gap_ok) model_lose();
                        else m_idx++;
                    end
`ifdef HWAG_GAP_CONFIRM_EN
                    else if (m_pend) begin
                        m_pend = 0;
                        if (2 * cur < m_gapp) begin m_lock = 1; m_idx = 1; e_gap = 1; end
                    end else if (gap_ok) begin
                        m_pend = 1; m_gapp = cur;
                    end
`else
                    else if (gap_ok) begin
                        m_lock = 1; m_idx = 0; e_gap = 1;
                    end
`endif
                    m_prev = cur;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at cycle %0d: observed=%0d expected=%0d", tag, m_now, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("period_out", period_out, m_period);
        chk("period_vld", period_vld, e_vld);
        chk("tooth_idx",  tooth_idx,  m_idx);
        chk("synced",     synced,     m_lock);
        chk("gap_det",    gap_det,    e_gap);
        chk("sync_err",   sync_err,   e_err);
        chk("ovf",        ovf,        e_ovf);
    endtask

    task automatic tick(input logic e);
        edge_in = e;
        @(posedge clk);
        model_step(e);
        #1;
        check_all();
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic edge_after(input int n);
        quiet(n - 1);
        tick(1'b1);
    endtask

    task automatic send_tooth();
        int p;
        p = $urandom_range(45, 25);
        edge_after(p);
        last_p = p;
    endtask

    task automatic send_gap();
        int g;
        g = 2 * last_p + $urandom_range(30, 0);
        if (g > 250) g = 250;
        edge_after(g);
        last_p = g;
    endtask

    task automatic restart(input int tn);
        ena = 1'b0;
        tick(1'b0);
        teeth_num = tn[TW-1:0];
        ena = 1'b1;
    endtask

    initial begin
        int  r, pos, tn;
        bit  ge;
        model_clear();
        rst = 1'b1; ena = 1'b0; edge_in = 1'b0; teeth_num = 8'd58;

        // Reset state
        tick(1'b0);
        tick(1'b0);
        chk("reset_period", period_out, 0);
        chk("reset_synced", synced, 0);
        rst = 1'b0;
        ena = 1'b1;

        // Acquisition: steady teeth then a triple-length gap
        edge_after(40);
        for (int i = 0; i < 4; i++) begin
            edge_after(40);
            chk("acq_period", period_out, 40);
            chk("acq_vld", period_vld, 1);
        end
        edge_after(120);
        last_p = 120;
        chk("acq_gap_period", period_out, 120);
`ifndef HWAG_GAP_CONFIRM_EN
        chk("acq_gap_det", gap_det, 1);
        chk("acq_synced", synced, 1);
        chk("acq_idx", tooth_idx, 0);
`endif

        // Two clean revolutions
        for (int rv = 0; rv < 2; rv++) begin
            for (int i = 0; i < 57; i++) send_tooth();
            send_gap();
        end
`ifndef HWAG_GAP_CONFIRM_EN
        chk("rev_gap_det", gap_det, 1);
        chk("rev_idx", tooth_idx, 0);
        chk("rev_synced", synced, 1);
        chk("rev_err", sync_err, 0);
`endif

        // Early gap at tooth 20, then resync on the next gap
        for (int i = 0; i < 20; i++) send_tooth();
        send_gap();
`ifndef HWAG_GAP_CONFIRM_EN
        chk("early_gap_err", sync_err, 1);
        chk("early_gap_synced", synced, 0);
        chk("early_gap_idx", tooth_idx, 0);
`endif
        for (int i = 0; i < 30; i++) send_tooth();
        send_gap();
`ifndef HWAG_GAP_CONFIRM_EN
        chk("resync_synced", synced, 1);
`endif

        // Missing gap: 58th period looks like a normal tooth
        for (int i = 0; i < 58; i++) send_tooth();
`ifndef HWAG_GAP_CONFIRM_EN
        chk("missing_gap_err", sync_err, 1);
        chk("missing_gap_synced", synced, 0);
`endif
        for (int i = 0; i < 10; i++) send_tooth();
        send_gap();

        // Stall, restart, and saturated periods
        quiet(SAT);
        chk("stall_ovf", ovf, 1);
        chk("stall_synced", synced, 0);
        edge_after(30);
        chk("stall_first_no_vld", period_vld, 0);
        edge_after(40);
        chk("stall_next_vld", period_vld, 1);
        chk("stall_next_period", period_out, 40);
        edge_after(SAT);
        chk("sat_edge_period", period_out, CMAX);
        chk("sat_edge_no_ovf", ovf, 0);
        edge_after(CMAX);
        chk("max_edge_period", period_out, CMAX);

        // Gap threshold boundary: 2*prev-1 is a tooth, 2*prev is a gap
        restart(58);
        edge_after(30);
        edge_after(30);
        edge_after(59);
`ifndef HWAG_GAP_CONFIRM_EN
        chk("below_2x_no_sync", synced, 0);
`endif
        edge_after(118);
`ifndef HWAG_GAP_CONFIRM_EN
        chk("at_2x_gap_det", gap_det, 1);
`endif
        last_p = 118;
        restart(58);
        chk("ena_low_period", period_out, 0);

        // Illegal teeth_num of zero
        restart(0);
        for (int i = 0; i < 4; i++) edge_after(40);
        edge_after(120);
        edge_after(40);
`ifndef HWAG_GAP_CONFIRM_EN
        chk("teeth0_err", sync_err, 1);
`endif

        // Randomized wheel with injected anomalies
        tn = $urandom_range(12, 3);
        restart(tn);
        pos = 0;
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(99, 0);
            if (r < 2) begin
                quiet(SAT + $urandom_range(3, 0));
            end else if (r < 3) begin
                tn = $urandom_range(12, 3);
                restart(tn);
                pos = 0;
            end else begin
                ge = (pos == 0);
                if (r < 8) ge = !ge;
                if (ge) send_gap(); else send_tooth();
                pos = (pos + 1) % tn;
            end
        end

        // Asynchronous reset in the middle of a synced revolution
        restart(58);
        last_p = 40;
        for (int i = 0; i < 4; i++) edge_after(40);
        edge_after(120);
        last_p = 120;
        for (int i = 0; i < 10; i++) send_tooth();
        edge_in = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        check_all();
        chk("async_rst_synced", synced, 0);
        chk("async_rst_idx", tooth_idx, 0);
        chk("async_rst_period", period_out, 0);
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) edge_after(40);
        edge_after(120);
        chk("post_rst_period", period_out, 120);
`ifndef HWAG_GAP_CONFIRM_EN
        chk("post_rst_synced", synced, 1);
`endif
        tick(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
